// File: rtl/kan_layer_sequencer_pkg.sv
// kan_pkg: shared types and default sizing for the KAN layer sequencer.
//   seq_state_e      run-control FSM states (IDLE=0, ISSUE=1, WAIT=2, FINISH=3)
//   KAN_MAX_LAYERS   default upper bound on layers per run
//   KAN_CNT_W        default run-cycle counter width
//   KAN_WDOG_CYCLES  default per-layer timeout (watchdog build only)
package kan_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } seq_state_e;

  localparam int KAN_MAX_LAYERS  = 8;
  localparam int KAN_CNT_W       = 32;
  localparam int KAN_WDOG_CYCLES = 1048576;
endpackage

// File: rtl/kan_layer_sequencer_if.sv
// kan_layer_if: layer command channel between sequencer and KAN datapath.
//   layer_valid/layer_ready  command handshake (sequencer -> datapath)
//   layer_idx                index of the commanded layer
//   layer_done               1-cycle pulse, datapath finished current layer
//   layer_flush              1-cycle pulse, datapath discards in-flight work
// master = sequencer side, slave = datapath side.
interface kan_layer_if
  import kan_pkg::*;
#(
  parameter int LAYER_W = $clog2(KAN_MAX_LAYERS)
);
  logic               layer_valid;
  logic               layer_ready;
  logic [LAYER_W-1:0] layer_idx;
  logic               layer_done;
  logic               layer_flush;

  modport master (output layer_valid, layer_idx, layer_flush,
                  input  layer_ready, layer_done);
  modport slave  (input  layer_valid, layer_idx, layer_flush,
                  output layer_ready, layer_done);
endinterface

// File: rtl/kan_sat_counter.sv
// kan_sat_counter: W-bit up-counter that sticks at all-ones.
//   clk_i, rst_i  clock, synchronous active-high reset
//   clr_i         synchronous clear (wins over en_i)
//   en_i          count enable
//   cnt_o         current count
module kan_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                  cnt_d = '0;
    else if (en_i && ~&cnt_q)   cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/kan_layer_sequencer.sv
// kan_layer_sequencer: run-control FSM between the control registers and the
// KAN datapath. A rising edge on ps_start launches a run of
// min(cfg_num_layers, MAX_LAYERS) layers; each layer is commanded over lif
// and its layer_done awaited before the next. ps_abort (in ISSUE/WAIT)
// flushes the datapath and ends the run with pl_err.
//   S_AXI_ACLK/S_AXI_ARESET  clock, synchronous active-high reset
//   ps_start, ps_abort       control-register level flags
//   cfg_num_layers           layer count, latched on start
//   lif (master)             layer command channel
//   pl_busy/pl_done/pl_err   status flags (done/err sticky until next start)
//   run_cycles               saturating busy-cycle count of last/current run
// Build option: define KAN_SEQ_WATCHDOG_EN to add a per-layer timeout of
// WDOG_CYCLES cycles that takes the abort path.
module kan_layer_sequencer
  import kan_pkg::*;
#(
  parameter int MAX_LAYERS  = KAN_MAX_LAYERS,
  parameter int LAYER_W     = $clog2(MAX_LAYERS),
  parameter int CNT_W       = KAN_CNT_W,
  parameter int WDOG_CYCLES = KAN_WDOG_CYCLES
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESET,
  input  logic               ps_start,
  input  logic               ps_abort,
  input  logic [LAYER_W:0]   cfg_num_layers,
  kan_layer_if.master        lif,
  output logic               pl_busy,
  output logic               pl_done,
  output logic               pl_err,
  output logic [CNT_W-1:0]   run_cycles
);
  localparam logic [LAYER_W:0] MAX_L = (LAYER_W+1)'(MAX_LAYERS);
  localparam logic [LAYER_W:0] ONE_L = (LAYER_W+1)'(1);

  seq_state_e         state_q, state_d;
  logic [LAYER_W-1:0] idx_q, idx_d;
  logic [LAYER_W:0]   n_q, n_d, n_clamp, idx_nxt;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               start_q, arm_q, start_edge;
  logic               valid_c, flush_c, run_clr, wd_fire, abort_c;

  // arm_q stays low until ps_start has been seen low after reset, so a
  // start flag held through reset cannot look like a fresh edge.
  assign start_edge = ps_start & ~start_q & arm_q;
  assign n_clamp    = (cfg_num_layers > MAX_L) ? MAX_L : cfg_num_layers;
  assign idx_nxt    = {1'b0, idx_q} + ONE_L;
  assign abort_c    = ps_abort | wd_fire;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    valid_c = 1'b0;
    flush_c = 1'b0;
    run_clr = 1'b0;
    case (state_q)
      IDLE: if (start_edge) begin
        n_d     = n_clamp;
        idx_d   = '0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
        run_clr = 1'b1;
        state_d = (n_clamp == '0) ? FINISH : ISSUE;
      end
      ISSUE: begin
        if (abort_c) begin
          flush_c = 1'b1;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          valid_c = 1'b1;
          if (lif.layer_ready) state_d = WAIT;
        end
      end
      WAIT: begin
        if (abort_c) begin
          flush_c = 1'b1;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (lif.layer_done) begin
          if (idx_nxt == n_q) state_d = FINISH;
          else begin
            idx_d   = idx_nxt[LAYER_W-1:0];
            state_d = ISSUE;
          end
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= ps_start;
      arm_q   <= arm_q | ~ps_start;
    end
  end

  kan_sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk_i (S_AXI_ACLK),
    .rst_i (S_AXI_ARESET),
    .clr_i (run_clr),
    .en_i  (busy_q),
    .cnt_o (run_cycles)
  );

`ifdef KAN_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_clr, wd_act;

  // Cleared on the edge into ISSUE, so it reads 0 in the first ISSUE cycle
  // and WDOG_CYCLES-1 in the WDOG_CYCLES-th cycle of the layer.
  assign wd_act  = (state_q == ISSUE) || (state_q == WAIT);
  assign wd_clr  = (state_d == ISSUE) && (state_q != ISSUE);
  assign wd_fire = wd_act && (wd_cnt == WD_W'(WDOG_CYCLES - 1));

  kan_sat_counter #(.W(WD_W)) u_wdog_cnt (
    .clk_i (S_AXI_ACLK),
    .rst_i (S_AXI_ARESET),
    .clr_i (wd_clr),
    .en_i  (wd_act),
    .cnt_o (wd_cnt)
  );
`else
  assign wd_fire = 1'b0;
`endif

  assign lif.layer_valid = valid_c;
  assign lif.layer_idx   = idx_q;
  assign lif.layer_flush = flush_c;
  assign pl_busy         = busy_q;
  assign pl_done         = done_q;
  assign pl_err          = err_q;
endmodule

// File: tb/tb_kan_layer_sequencer.sv
module tb_kan_layer_sequencer;
  import kan_pkg::*;

  localparam int MAXL = 8;
  localparam int LW   = 3;
  localparam int CW   = 32;
`ifdef KAN_SEQ_WATCHDOG_EN
  localparam int WD = 16;
`else
  localparam int WD = 1048576;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ps_start = 1'b0;
  logic          ps_abort = 1'b0;
  logic [LW:0]   cfg = '0;
  logic          pl_busy, pl_done, pl_err;
  logic [CW-1:0] run_cycles;

  kan_layer_if #(.LAYER_W(LW)) lif ();

  kan_layer_sequencer #(
    .MAX_LAYERS(MAXL), .LAYER_W(LW), .CNT_W(CW), .WDOG_CYCLES(WD)
  ) dut (
    .S_AXI_ACLK     (clk),
    .S_AXI_ARESET   (rst),
    .ps_start       (ps_start),
    .ps_abort       (ps_abort),
    .cfg_num_layers (cfg),
    .lif            (lif),
    .pl_busy        (pl_busy),
    .pl_done        (pl_done),
    .pl_err         (pl_err),
    .run_cycles     (run_cycles)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not expected / not seen", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outcome of one run, derived from the protocol: each accepted
  // layer costs (ready stall + 1 issue cycle + cycles waiting for done),
  // a normal run adds the single FINISH cycle.
  typedef struct {
    bit          done;
    bit          err;
    int unsigned cyc;
    int          layers;
    int          flushes;
    int          vcyc;
  } run_exp_t;

  int       exp_idx_q[$];
  run_exp_t exp_run_q[$];

  // Monitor: decoupled from stimulus, samples on the falling edge.
  int          acc_cnt, fl_cnt, v_cnt;
  bit          busy_prev, pv;
  logic [LW-1:0] pidx;
  run_exp_t    me;

  always @(negedge clk) begin
    if (rst) begin
      busy_prev = 0; pv = 0; acc_cnt = 0; fl_cnt = 0; v_cnt = 0;
    end else begin
      if (pv && !ps_abort) begin
        chk("valid_hold", 64'(lif.layer_valid), 64'd1);
        chk("idx_hold", 64'(lif.layer_idx), 64'(pidx));
      end
      if (lif.layer_valid) v_cnt++;
      if (lif.layer_valid && lif.layer_ready) begin
        acc_cnt++;
        if (exp_idx_q.size() == 0) fail_evt("unexpected_accept");
        else chk("layer_idx", 64'(lif.layer_idx), 64'(exp_idx_q.pop_front()));
      end
      if (lif.layer_flush) fl_cnt++;
      pv   = lif.layer_valid && !lif.layer_ready;
      pidx = lif.layer_idx;
      if (busy_prev && !pl_busy) begin
        if (exp_run_q.size() == 0) fail_evt("unexpected_run_end");
        else begin
          me = exp_run_q.pop_front();
          chk("pl_done", 64'(pl_done), 64'(me.done));
          chk("pl_err", 64'(pl_err), 64'(me.err));
          chk("run_cycles", 64'(run_cycles), 64'(me.cyc));
          chk("accepts", 64'(acc_cnt), 64'(me.layers));
          chk("flush_cycles", 64'(fl_cnt), 64'(me.flushes));
          chk("valid_cycles", 64'(v_cnt), 64'(me.vcyc));
        end
        acc_cnt = 0; fl_cnt = 0; v_cnt = 0;
      end
      busy_prev = pl_busy;
    end
  end

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget && exp_run_q.size() != 0; i++) @(negedge clk);
    if (exp_run_q.size() != 0) begin
      fail_evt("run_end_timeout");
      exp_run_q.delete();
      exp_idx_q.delete();
    end
  endtask

  // ab_mode: 0 none, 1 abort in first ISSUE cycle (ready high too),
  // 2 abort in WAIT cycle ab_w (<1 = random), 3 no done, DUT watchdog fires.
  task automatic do_run(input int cfg_v, input int ab_layer, input int ab_mode_in,
                        input int ab_w_in, input int st_fix, input int d_fix,
                        input bit disturb);
    int       n, ab_w, ab_mode;
    int       st[MAXL];
    int       d[MAXL];
    run_exp_t e;
    n       = (cfg_v > MAXL) ? MAXL : cfg_v;
    ab_mode = (ab_layer < 0 || ab_layer >= n) ? 0 : ab_mode_in;
    ab_w    = ab_w_in;
    e       = '{default: 0};
    for (int k = 0; k < n; k++) begin
      st[k] = (st_fix >= 0) ? st_fix : int'($urandom_range(0, 4));
      d[k]  = (d_fix > 0) ? d_fix : int'($urandom_range(1, 6));
    end
    if (ab_mode == 2 && ab_w < 1) ab_w = int'($urandom_range(1, d[ab_layer]));
    for (int k = 0; k < n; k++) begin
      if (ab_mode == 1 && k == ab_layer) begin e.cyc += 1; e.err = 1; break; end
      exp_idx_q.push_back(k);
      e.layers++;
      e.vcyc += st[k] + 1;
      if (ab_mode >= 2 && k == ab_layer) begin
        e.cyc += st[k] + 1 + ab_w; e.err = 1; break;
      end
      e.cyc += st[k] + 1 + d[k];
    end
    if (!e.err) e.cyc += 1;
    e.done    = !e.err;
    e.flushes = e.err ? 1 : 0;
    exp_run_q.push_back(e);

    tick();
    cfg = cfg_v[LW:0];
    ps_start = 1'b1;
    tick();
    ps_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (ab_mode == 1 && k == ab_layer) begin
        lif.layer_ready = 1'b1; ps_abort = 1'b1;
        tick();
        lif.layer_ready = 1'b0; ps_abort = 1'b0;
        break;
      end
      for (int s = 0; s < st[k]; s++) begin
        lif.layer_done = disturb && k == 0 && s == 0;
        tick();
      end
      lif.layer_done  = 1'b0;
      lif.layer_ready = 1'b1;
      tick();
      lif.layer_ready = 1'b0;
      if (ab_mode == 3 && k == ab_layer) break;
      if (ab_mode == 2 && k == ab_layer) begin
        repeat (ab_w - 1) tick();
        ps_abort = 1'b1;
        lif.layer_done = (ab_w == d[k]);
        tick();
        ps_abort = 1'b0; lif.layer_done = 1'b0;
        break;
      end
      ps_start = disturb && k == 0;
      for (int i = 1; i < d[k]; i++) begin tick(); ps_start = 1'b0; end
      lif.layer_done = 1'b1;
      tick();
      lif.layer_done = 1'b0;
      ps_start = 1'b0;
    end
    wait_end(ab_mode == 3 ? WD + 50 : 60);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cv, nl, md, al;
    lif.layer_ready = 1'b0;
    lif.layer_done  = 1'b0;

    // Start flag held high through reset must not launch a run.
    ps_start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(pl_busy), 64'd0);
    chk("rst_valid", 64'(lif.layer_valid), 64'd0);
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("held_start_busy", 64'(pl_busy), 64'd0);
      chk("held_start_valid", 64'(lif.layer_valid), 64'd0);
    end
    chk("idle_done", 64'(pl_done), 64'd0);
    chk("idle_err", 64'(pl_err), 64'd0);
    chk("idle_run_cycles", 64'(run_cycles), 64'd0);
    chk("idle_flush", 64'(lif.layer_flush), 64'd0);
    tick();
    ps_start = 1'b0;
    tick();

    do_run(3, -1, 0, 0, 0, 5, 1'b0);      // 3 layers, ready tied, done +5
    do_run(0, -1, 0, 0, 0, 1, 1'b0);      // empty run
    do_run(2, 0, 2, 3, 10, 6, 1'b0);      // 10-cycle stall, abort in WAIT
    do_run(4, -1, 0, 0, 2, -1, 1'b1);     // done in ISSUE + start mid-run
    do_run(5, 2, 1, 0, -1, -1, 1'b0);     // abort beats ready
    do_run(3, 1, 2, 4, -1, 4, 1'b0);      // abort beats done
    do_run(15, -1, 0, 0, -1, -1, 1'b0);   // clamp to MAX_LAYERS
    do_run(8, -1, 0, 0, 0, 1, 1'b0);      // back-to-back layers

    repeat (25) begin
      cv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      nl = (cv > MAXL) ? MAXL : cv;
      md = int'($urandom_range(0, 3));
      md = (md == 3) ? 0 : md;
      al = (nl > 0) ? int'($urandom_range(0, nl - 1)) : -1;
      do_run(cv, al, md, -1, -1, -1, 1'($urandom_range(0, 1)));
    end

`ifdef KAN_SEQ_WATCHDOG_EN
    do_run(1, 0, 3, WD - 1, 0, 1, 1'b0);  // no done: timeout at cycle WD
`endif

    // Reset mid-run: outputs return to reset values, no flush.
    tick();
    cfg = 4'd3;
    ps_start = 1'b1;
    tick();
    ps_start = 1'b0;
    exp_idx_q.push_back(0);
    lif.layer_ready = 1'b1;
    tick();
    lif.layer_ready = 1'b0;
    tick();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", 64'(pl_busy), 64'd0);
    chk("midrst_valid", 64'(lif.layer_valid), 64'd0);
    chk("midrst_flush", 64'(lif.layer_flush), 64'd0);
    chk("midrst_idx", 64'(lif.layer_idx), 64'd0);
    chk("midrst_done", 64'(pl_done), 64'd0);
    chk("midrst_err", 64'(pl_err), 64'd0);
    chk("midrst_run_cycles", 64'(run_cycles), 64'd0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 64'(pl_busy), 64'd0);
    chk("idx_queue_drained", 64'(exp_idx_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
